// File: rtl/drp_rmw_master.sv
// drp_rmw_master
//   Single-clock DRP transaction master. Takes one command at a time (read,
//   write or masked read-modify-write), runs the DRP EN/WE/RDY handshake and
//   returns exactly one response per command. Every wait for RDY is bounded by
//   TIMEOUT_CYCLES, so a response is always produced.
//
// Ports
//   DRPCLK_I, DRPRSTN_I      clock, synchronous active-low reset
//   CMD_VALID_I/CMD_READY_O  command handshake (ready only while idle)
//   CMD_OP_I                 00 read, 01 write, 10 RMW, 11 handled as read
//   CMD_ADDR_I/DATA_I/MASK_I command address, write/insert data, RMW mask
//   RSP_VALID_O              one-cycle response pulse
//   RSP_DATA_O               read data, or the value written; 0 on timeout
//   RSP_TIMEOUT_O            response is the result of a timed-out access
//   BUSY_O                   a command is in progress
//   M_DRP*                   DRP master port (EN is a single-cycle pulse)
module drp_rmw_master #(
  parameter int ADDR_WIDTH     = 9,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  DRPCLK_I,
  input  logic                  DRPRSTN_I,
  input  logic                  CMD_VALID_I,
  output logic                  CMD_READY_O,
  input  logic [1:0]            CMD_OP_I,
  input  logic [ADDR_WIDTH-1:0] CMD_ADDR_I,
  input  logic [DATA_WIDTH-1:0] CMD_DATA_I,
  input  logic [DATA_WIDTH-1:0] CMD_MASK_I,
  output logic                  RSP_VALID_O,
  output logic [DATA_WIDTH-1:0] RSP_DATA_O,
  output logic                  RSP_TIMEOUT_O,
  output logic                  BUSY_O,
  output logic [ADDR_WIDTH-1:0] M_DRPADDR_O,
  output logic [DATA_WIDTH-1:0] M_DRPDI_O,
  input  logic [DATA_WIDTH-1:0] M_DRPDO_I,
  output logic                  M_DRPEN_O,
  output logic                  M_DRPWE_O,
  input  logic                  M_DRPRDY_I
);

  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_RESP
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  is_rmw_q, is_rmw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;

  logic [DATA_WIDTH-1:0] merged;
  logic                  wait_expired;

  // Next values of the registered outputs
  logic                  cmd_ready_d;
  logic                  busy_d;
  logic                  en_d;
  logic                  we_d;
  logic [ADDR_WIDTH-1:0] drpaddr_d;
  logic [DATA_WIDTH-1:0] drpdi_d;
  logic                  rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_d;
  logic                  rsp_to_d;

  // RMW write value is built straight from the returning read data, so the
  // write request can be issued on the edge that samples the read RDY.
  assign merged = (M_DRPDO_I & ~mask_q) | (data_q & mask_q);

  // cnt_q counts completed WAIT cycles without RDY; reaching CNT_LAST in a
  // cycle that still has no RDY means TIMEOUT_CYCLES waits have elapsed.
  assign wait_expired = (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_rmw_d    = is_rmw_q;
    addr_d      = addr_q;
    data_d      = data_q;
    mask_d      = mask_q;
    en_d        = 1'b0;
    we_d        = 1'b0;
    drpaddr_d   = M_DRPADDR_O;
    drpdi_d     = M_DRPDI_O;
    rsp_valid_d = 1'b0;
    rsp_data_d  = '0;
    rsp_to_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (CMD_VALID_I && CMD_READY_O) begin
          is_rmw_d  = (CMD_OP_I == 2'b10);
          addr_d    = CMD_ADDR_I;
          data_d    = CMD_DATA_I;
          mask_d    = CMD_MASK_I;
          en_d      = 1'b1;
          drpaddr_d = CMD_ADDR_I;
          if (CMD_OP_I == 2'b01) begin
            state_d = S_WR_REQ;
            we_d    = 1'b1;
            drpdi_d = CMD_DATA_I;
          end else begin
            state_d = S_RD_REQ;
          end
        end
      end

      S_RD_REQ: begin
        state_d = S_RD_WAIT;
        cnt_d   = '0;
      end

      S_RD_WAIT: begin
        if (M_DRPRDY_I) begin
          if (is_rmw_q) begin
            state_d   = S_WR_REQ;
            en_d      = 1'b1;
            we_d      = 1'b1;
            drpaddr_d = addr_q;
            drpdi_d   = merged;
          end else begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = M_DRPDO_I;
          end
        end else if (wait_expired) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end

      S_WR_REQ: begin
        state_d = S_WR_WAIT;
        cnt_d   = '0;
      end

      S_WR_WAIT: begin
        if (M_DRPRDY_I) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = M_DRPDI_O;
        end else if (wait_expired) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge DRPCLK_I) begin
    if (!DRPRSTN_I) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      is_rmw_q      <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      mask_q        <= '0;
      CMD_READY_O   <= 1'b0;
      BUSY_O        <= 1'b0;
      M_DRPEN_O     <= 1'b0;
      M_DRPWE_O     <= 1'b0;
      M_DRPADDR_O   <= '0;
      M_DRPDI_O     <= '0;
      RSP_VALID_O   <= 1'b0;
      RSP_DATA_O    <= '0;
      RSP_TIMEOUT_O <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      is_rmw_q      <= is_rmw_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      mask_q        <= mask_d;
      CMD_READY_O   <= cmd_ready_d;
      BUSY_O        <= busy_d;
      M_DRPEN_O     <= en_d;
      M_DRPWE_O     <= we_d;
      M_DRPADDR_O   <= drpaddr_d;
      M_DRPDI_O     <= drpdi_d;
      RSP_VALID_O   <= rsp_valid_d;
      RSP_DATA_O    <= rsp_data_d;
      RSP_TIMEOUT_O <= rsp_to_d;
    end
  end

endmodule

// File: tb/tb_drp_rmw_master.sv
// Testbench for drp_rmw_master. Two instances: u0 with the default timeout,
// u1 with TIMEOUT_CYCLES=8 for the timeout boundaries. The bench plays the
// DRP slave itself and predicts EN pulses and responses from the command,
// the RDY delays and the timeout limit.
`timescale 1ns/1ps
module tb_drp_rmw_master;
  localparam int AW = 9;
  localparam int DW = 16;
  localparam int T0 = 1023;
  localparam int T1 = 8;

  typedef struct {
    int            cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] di;
  } en_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn      [2];
  logic          cmd_valid [2];
  logic          cmd_ready [2];
  logic [1:0]    cmd_op    [2];
  logic [AW-1:0] cmd_addr  [2];
  logic [DW-1:0] cmd_data  [2];
  logic [DW-1:0] cmd_mask  [2];
  logic          rsp_valid [2];
  logic [DW-1:0] rsp_data  [2];
  logic          rsp_to    [2];
  logic          busy      [2];
  logic [AW-1:0] drp_addr  [2];
  logic [DW-1:0] drp_di    [2];
  logic [DW-1:0] drp_do    [2];
  logic          drp_en    [2];
  logic          drp_we    [2];
  logic          drp_rdy   [2];

  drp_rmw_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T0)) u0 (
    .DRPCLK_I(clk), .DRPRSTN_I(rstn[0]),
    .CMD_VALID_I(cmd_valid[0]), .CMD_READY_O(cmd_ready[0]), .CMD_OP_I(cmd_op[0]),
    .CMD_ADDR_I(cmd_addr[0]), .CMD_DATA_I(cmd_data[0]), .CMD_MASK_I(cmd_mask[0]),
    .RSP_VALID_O(rsp_valid[0]), .RSP_DATA_O(rsp_data[0]), .RSP_TIMEOUT_O(rsp_to[0]),
    .BUSY_O(busy[0]), .M_DRPADDR_O(drp_addr[0]), .M_DRPDI_O(drp_di[0]),
    .M_DRPDO_I(drp_do[0]), .M_DRPEN_O(drp_en[0]), .M_DRPWE_O(drp_we[0]),
    .M_DRPRDY_I(drp_rdy[0])
  );

  drp_rmw_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T1)) u1 (
    .DRPCLK_I(clk), .DRPRSTN_I(rstn[1]),
    .CMD_VALID_I(cmd_valid[1]), .CMD_READY_O(cmd_ready[1]), .CMD_OP_I(cmd_op[1]),
    .CMD_ADDR_I(cmd_addr[1]), .CMD_DATA_I(cmd_data[1]), .CMD_MASK_I(cmd_mask[1]),
    .RSP_VALID_O(rsp_valid[1]), .RSP_DATA_O(rsp_data[1]), .RSP_TIMEOUT_O(rsp_to[1]),
    .BUSY_O(busy[1]), .M_DRPADDR_O(drp_addr[1]), .M_DRPDI_O(drp_di[1]),
    .M_DRPDO_I(drp_do[1]), .M_DRPEN_O(drp_en[1]), .M_DRPWE_O(drp_we[1]),
    .M_DRPRDY_I(drp_rdy[1])
  );

  int npass = 0;
  int nchk  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One command on instance u. k_rd/k_wr: RDY comes k cycles after the
  // matching EN; 0 means RDY never comes. Caller is at a negedge.
  task automatic do_cmd(input int u, input string tag, input logic [1:0] op,
                        input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic [DW-1:0] mask, input logic [DW-1:0] rdval,
                        input int k_rd, input int k_wr);
    en_t           exp_en[$];
    en_t           got_en[$];
    int            t, exp_rc, got_rc, nrsp, rdy_at, w, k;
    logic          exp_to, got_to;
    logic [DW-1:0] exp_dat, got_dat, merged;

    t      = (u == 0) ? T0 : T1;
    merged = (rdval & ~mask) | (data & mask);
    if (op == 2'b01) begin
      exp_en.push_back(en_t'{1, 1'b1, addr, data});
      if (k_wr >= 1 && k_wr <= t) begin exp_rc = k_wr + 2; exp_to = 1'b0; exp_dat = data; end
      else begin exp_rc = t + 2; exp_to = 1'b1; exp_dat = '0; end
    end else begin
      exp_en.push_back(en_t'{1, 1'b0, addr, '0});
      if (!(k_rd >= 1 && k_rd <= t)) begin
        exp_rc = t + 2; exp_to = 1'b1; exp_dat = '0;
      end else if (op != 2'b10) begin
        exp_rc = k_rd + 2; exp_to = 1'b0; exp_dat = rdval;
      end else begin
        exp_en.push_back(en_t'{k_rd + 2, 1'b1, addr, merged});
        if (k_wr >= 1 && k_wr <= t) begin exp_rc = k_rd + k_wr + 3; exp_to = 1'b0; exp_dat = merged; end
        else begin exp_rc = k_rd + t + 3; exp_to = 1'b1; exp_dat = '0; end
      end
    end

    w = 0;
    while (cmd_ready[u] !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    check({tag, ":ready_before"}, cmd_ready[u], 1'b1);

    cmd_valid[u] = 1'b1; cmd_op[u] = op; cmd_addr[u] = addr;
    cmd_data[u] = data; cmd_mask[u] = mask;
    got_rc = -1; nrsp = 0; rdy_at = -1; got_dat = '0; got_to = 1'b0;

    for (int c = 1; c <= exp_rc + 1; c++) begin
      @(negedge clk);
      // Scramble command inputs after accept: the DUT must use latched values
      cmd_valid[u] = 1'b0;
      cmd_op[u]    = 2'($urandom_range(0, 3));
      cmd_addr[u]  = AW'($urandom);
      cmd_data[u]  = DW'($urandom);
      cmd_mask[u]  = DW'($urandom);
      if (drp_en[u] === 1'b1) begin
        got_en.push_back(en_t'{c, drp_we[u], drp_addr[u], drp_di[u]});
        k = (got_en.size() == 1 && op != 2'b01) ? k_rd : k_wr;
        rdy_at = (k > 0) ? c + k : -1;
      end
      if (rsp_valid[u] === 1'b1) begin
        nrsp++;
        if (got_rc < 0) begin got_rc = c; got_dat = rsp_data[u]; got_to = rsp_to[u]; end
      end
      if (c == rdy_at) begin drp_rdy[u] = 1'b1; drp_do[u] = rdval; end
      else begin drp_rdy[u] = 1'b0; drp_do[u] = DW'($urandom); end
    end
    drp_rdy[u] = 1'b0;

    check({tag, ":en_count"}, got_en.size(), exp_en.size());
    for (int i = 0; i < exp_en.size() && i < got_en.size(); i++) begin
      check({tag, $sformatf(":en%0d_cycle", i)}, got_en[i].cyc, exp_en[i].cyc);
      check({tag, $sformatf(":en%0d_we", i)}, got_en[i].we, exp_en[i].we);
      check({tag, $sformatf(":en%0d_addr", i)}, got_en[i].addr, exp_en[i].addr);
      if (exp_en[i].we) check({tag, $sformatf(":en%0d_di", i)}, got_en[i].di, exp_en[i].di);
    end
    check({tag, ":rsp_count"}, nrsp, 1);
    check({tag, ":rsp_cycle"}, got_rc, exp_rc);
    check({tag, ":rsp_data"}, got_dat, exp_dat);
    check({tag, ":rsp_timeout"}, got_to, exp_to);
    check({tag, ":busy_after"}, busy[u], 1'b0);
    check({tag, ":ready_after"}, cmd_ready[u], 1'b1);
  endtask

  // RDY pulse while idle must be ignored
  task automatic stray_rdy(input int u, input string tag);
    int nr, ne;
    nr = 0; ne = 0;
    drp_rdy[u] = 1'b1; drp_do[u] = DW'($urandom);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drp_rdy[u] = 1'b0;
      if (rsp_valid[u] === 1'b1) nr++;
      if (drp_en[u] === 1'b1) ne++;
    end
    check({tag, ":no_rsp"}, nr, 0);
    check({tag, ":no_en"}, ne, 0);
    check({tag, ":ready"}, cmd_ready[u], 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] b_addr [3];
    logic [DW-1:0] b_do   [3];
    int            b_k    [3];
    int            nacc, nrsp, nen, rdy_at, upd, bc;

    for (int u = 0; u < 2; u++) begin
      rstn[u] = 1'b0; cmd_valid[u] = 1'b0; cmd_op[u] = '0; cmd_addr[u] = '0;
      cmd_data[u] = '0; cmd_mask[u] = '0; drp_do[u] = '0; drp_rdy[u] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check($sformatf("reset_outputs%0d", u),
            {cmd_ready[u], rsp_valid[u], rsp_data[u], rsp_to[u], busy[u],
             drp_addr[u], drp_di[u], drp_en[u], drp_we[u]}, '0);
      rstn[u] = 1'b1;
    end
    @(negedge clk);
    check("ready_after_reset0", cmd_ready[0], 1'b1);
    check("ready_after_reset1", cmd_ready[1], 1'b1);

    // Directed transactions
    do_cmd(0, "read",  2'b00, 9'h0E7, 16'h0000, 16'h0000, 16'h78F9, 20, 0);
    do_cmd(0, "write", 2'b01, 9'h0E7, 16'h04CF, 16'h0000, 16'h0000, 0, 5);
    do_cmd(0, "rmw",   2'b10, 9'h0E7, 16'h04CF, 16'h00FF, 16'h78F9, 3, 4);
    do_cmd(0, "op11",  2'b11, 9'h155, 16'hAAAA, 16'hFFFF, 16'h1234, 1, 0);

    // Timeout boundaries on the TIMEOUT_CYCLES=8 instance
    do_cmd(1, "rmw_rd_timeout", 2'b10, 9'h0E7, 16'h04CF, 16'h00FF, 16'h78F9, 0, 0);
    stray_rdy(1, "stray_idle");
    do_cmd(1, "rmw_rdy_last",   2'b10, 9'h0E7, 16'h04CF, 16'h00FF, 16'h78F9, 8, 8);
    do_cmd(1, "rd_rdy_late",    2'b00, 9'h011, 16'h0000, 16'h0000, 16'hBEEF, 9, 0);
    do_cmd(1, "wr_timeout",     2'b01, 9'h022, 16'hC0DE, 16'h0000, 16'h0000, 0, 0);
    do_cmd(1, "rmw_wr_timeout", 2'b10, 9'h033, 16'hF0F0, 16'h0FF0, 16'h5A5A, 2, 9);

    // Reset in the middle of a read (edge taken while in RD_WAIT)
    cmd_valid[0] = 1'b1; cmd_op[0] = 2'b00; cmd_addr[0] = 9'h0A5;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    check("midrst:en_req", drp_en[0], 1'b1);
    @(negedge clk);
    check("midrst:busy_wait", busy[0], 1'b1);
    rstn[0] = 1'b0;
    @(negedge clk);
    check("midrst:outputs", {drp_en[0], drp_we[0], rsp_valid[0], cmd_ready[0], busy[0]}, '0);
    rstn[0] = 1'b1;
    drp_rdy[0] = 1'b1; drp_do[0] = 16'hDEAD;
    @(negedge clk);
    check("midrst:ready_release", cmd_ready[0], 1'b1);
    stray_rdy(0, "midrst_late_rdy");

    // Back-to-back reads with CMD_VALID held high
    for (int i = 0; i < 3; i++) begin
      b_addr[i] = AW'($urandom); b_do[i] = DW'($urandom); b_k[i] = $urandom_range(1, 4);
    end
    nacc = 0; nrsp = 0; nen = 0; rdy_at = -1; upd = 0; bc = 0;
    cmd_valid[0] = 1'b1; cmd_op[0] = 2'b00; cmd_addr[0] = b_addr[0];
    while (nrsp < 3 && bc < 200) begin
      if (rsp_valid[0] === 1'b1) begin
        check($sformatf("b2b:rsp%0d_data", nrsp), rsp_data[0], b_do[nrsp]);
        nrsp++;
      end
      if (drp_en[0] === 1'b1) begin
        nen++;
        check($sformatf("b2b:en%0d_prev_done", nen), nrsp, nen - 1);
        check($sformatf("b2b:en%0d_addr", nen), drp_addr[0], b_addr[nen - 1]);
        rdy_at = bc + b_k[nen - 1];
      end
      if (cmd_ready[0] === 1'b1 && cmd_valid[0] === 1'b1) begin
        check($sformatf("b2b:acc%0d_idle", nacc), busy[0], 1'b0);
        nacc++;
        upd = 1;
      end else if (upd == 1) begin
        upd = 0;
        if (nacc < 3) cmd_addr[0] = b_addr[nacc];
        else cmd_valid[0] = 1'b0;
      end
      if (bc == rdy_at) begin drp_rdy[0] = 1'b1; drp_do[0] = b_do[nen - 1]; end
      else begin drp_rdy[0] = 1'b0; drp_do[0] = DW'($urandom); end
      @(negedge clk);
      bc++;
    end
    cmd_valid[0] = 1'b0; drp_rdy[0] = 1'b0;
    check("b2b:accepts", nacc, 3);
    check("b2b:responses", nrsp, 3);
    check("b2b:en_count", nen, 3);

    // Randomized commands against the reference
    for (int i = 0; i < 12; i++)
      do_cmd(0, $sformatf("rand0_%0d", i), 2'($urandom_range(0, 3)), AW'($urandom),
             DW'($urandom), DW'($urandom), DW'($urandom),
             $urandom_range(1, 6), $urandom_range(1, 6));
    for (int i = 0; i < 8; i++)
      do_cmd(1, $sformatf("rand1_%0d", i), 2'($urandom_range(0, 3)), AW'($urandom),
             DW'($urandom), DW'($urandom), DW'($urandom),
             $urandom_range(0, 10), $urandom_range(0, 10));

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
